// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Register map and bit layout shared by the UART receive-side blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam logic [1:0] UART_RXF_DATA   = 2'b00;
  localparam logic [1:0] UART_RXF_STATUS = 2'b01;
  localparam logic [1:0] UART_RXF_COUNT  = 2'b10;
  localparam logic [1:0] UART_RXF_CTRL   = 2'b11;

  localparam int STATUS_NOT_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT      = 1;
  localparam int STATUS_OVERRUN_BIT   = 2;

  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVR_BIT = 1;

  typedef struct packed {
    logic [4:0] rsvd;
    logic       overrun;
    logic       full;
    logic       not_empty;
  } rxf_status_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module : sync_fifo_mem
// Brief  : DEPTH x 8 storage, one synchronous write port, asynchronous read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module : uart_rx_fifo
// Brief  : UART receive FIFO with a 4-register read/control window on the bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       rd_en,
  input  logic       wr_en,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq
);

  localparam int CW = AW + 1;

  logic          rx_valid_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;

  logic          w_push, w_pop, w_push_ok, w_overflow;
  logic          w_ctrl_wr, w_flush, w_clr_ovr;
  logic          w_full, w_not_empty;
  logic [7:0]    w_head, w_count8, w_rdata;
  rxf_status_t   w_status;
  logic          w_unused_wdata;

  assign w_full      = (count_q == CW'(DEPTH));
  assign w_not_empty = (count_q != '0);

  assign w_push    = rx_valid & ~rx_valid_q;
  assign w_pop     = ~cs & rd_en & (addr == UART_RXF_DATA) & w_not_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok  = w_push & (~w_full | w_pop);
  assign w_overflow = w_push & w_full & ~w_pop;

  assign w_ctrl_wr = ~cs & wr_en & (addr == UART_RXF_CTRL);
  assign w_flush   = w_ctrl_wr & wdata[CTRL_FLUSH_BIT];
  assign w_clr_ovr = w_ctrl_wr & wdata[CTRL_CLR_OVR_BIT];
  assign w_unused_wdata = ^wdata[7:2];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (w_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (w_push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(w_push_ok) - CW'(w_pop);
    end
    if (w_clr_ovr)  overrun_d = 1'b0;
    if (w_overflow) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (w_push_ok & ~w_flush),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (rx_byte),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (w_head)
  );

  // COUNT is an 8-bit register; only DEPTH=256 can exceed it and saturates.
  generate
    if (CW <= 8) begin : g_cnt_zext
      assign w_count8 = 8'(count_q);
    end else begin : g_cnt_sat
      assign w_count8 = (count_q > CW'(255)) ? 8'hFF : count_q[7:0];
    end
  endgenerate

  always_comb begin
    w_status           = '0;
    w_status.overrun   = overrun_q;
    w_status.full      = w_full;
    w_status.not_empty = w_not_empty;
    w_rdata            = 8'h00;
    case (addr)
      UART_RXF_DATA:   w_rdata = w_not_empty ? w_head : 8'h00;
      UART_RXF_STATUS: w_rdata = w_status;
      UART_RXF_COUNT:  w_rdata = w_count8;
      UART_RXF_CTRL:   w_rdata = {6'b0, overrun_q, 1'b0};
      default:         w_rdata = 8'h00;
    endcase
  end

  assign rdata = cs ? 8'hzz : w_rdata;
  assign irq   = w_not_empty | overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module : tb_uart_rx_fifo
// Brief  : Directed scenarios plus random traffic against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n, rx_valid, cs, rd_en, wr_en;
  logic [7:0] rx_byte, wdata;
  logic [1:0] addr;
  wire  [7:0] rdata;
  wire        irq;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_ovr;
  logic       m_prev;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .cs       (cs),
    .addr     (addr),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_rdata(input logic [1:0] a);
    int n = mq.size();
    case (a)
      2'd0:    return (n > 0) ? mq[0] : 8'h00;
      2'd1:    return {5'b0, m_ovr, n == DEPTH, n != 0};
      2'd2:    return 8'(n);
      default: return {6'b0, m_ovr, 1'b0};
    endcase
  endfunction

  function automatic logic m_irq();
    return (mq.size() != 0) || m_ovr;
  endfunction

  task automatic m_update();
    logic push, pop, ctrl;
    if (!rst_n) begin
      mq.delete();
      m_ovr  = 1'b0;
      m_prev = 1'b0;
      return;
    end
    push   = rx_valid && !m_prev;
    m_prev = rx_valid;
    pop    = !cs && rd_en && addr == 2'd0 && mq.size() > 0;
    ctrl   = !cs && wr_en && addr == 2'd3;
    if (ctrl && wdata[1]) m_ovr = 1'b0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(rx_byte);
      else m_ovr = 1'b1;
    end
    if (ctrl && wdata[0]) mq.delete();
  endtask

  // Inputs are set at the negedge; check just after, then advance one clock.
  task automatic step();
    #1;
    if (!cs) chk("rdata", rdata, m_rdata(addr));
    chk("irq", {7'b0, irq}, {7'b0, m_irq()});
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic bus_idle();
    cs = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = 2'd0; wdata = 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1; step();
    rx_valid = 1'b0; step();
  endtask

  task automatic rd_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    cs = 1'b0; addr = a; rd_en = 1'b1;
    #1 chk(tag, rdata, exp);
    step();
    bus_idle();
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    cs = 1'b0; addr = 2'd3; wr_en = 1'b1; wdata = d;
    step();
    bus_idle();
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    bus_idle();
    repeat (3) @(posedge clk);
    mq.delete(); m_ovr = 1'b0; m_prev = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    chk("rst_irq", {7'b0, irq}, 8'h00);

    // 1: single byte round trip
    rd_reg("t1_status0", 2'd1, 8'h00);
    push_byte(8'h41);
    rd_reg("t1_status", 2'd1, 8'h01);
    rd_reg("t1_count", 2'd2, 8'h01);
    rd_reg("t1_data", 2'd0, 8'h41);
    rd_reg("t1_status_after", 2'd1, 8'h00);

    // 2: fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    rd_reg("t2_status_full", 2'd1, 8'h03);
    rd_reg("t2_count_full", 2'd2, 8'h10);
    push_byte(8'hAA);
    rd_reg("t2_status_ovr", 2'd1, 8'h07);
    chk("t2_irq", {7'b0, irq}, 8'h01);
    for (int i = 0; i < DEPTH; i++) rd_reg("t2_drain", 2'd0, 8'(i));
    rd_reg("t2_status_empty", 2'd1, 8'h04);

    // 5a: clear overrun
    wr_ctrl(8'h02);
    rd_reg("t5_status_clr", 2'd1, 8'h00);

    // 3: level held high is one push
    rx_byte = 8'h55; rx_valid = 1'b1;
    repeat (50) step();
    rx_valid = 1'b0; step();
    rd_reg("t3_count", 2'd2, 8'h01);
    rd_reg("t3_data", 2'd0, 8'h55);

    // 4: push and pop together while full
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    rx_byte = 8'h99; rx_valid = 1'b1; cs = 1'b0; addr = 2'd0; rd_en = 1'b1;
    #1 chk("t4_pop", rdata, 8'h00);
    step();
    rx_valid = 1'b0; bus_idle(); step();
    rd_reg("t4_count", 2'd2, 8'h10);
    rd_reg("t4_status", 2'd1, 8'h03);
    for (int i = 1; i < DEPTH; i++) rd_reg("t4_drain", 2'd0, 8'(i));
    rd_reg("t4_last", 2'd0, 8'h99);

    // 5b: flush
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    wr_ctrl(8'h01);
    rd_reg("t5_count_flush", 2'd2, 8'h00);
    chk("t5_irq", {7'b0, irq}, 8'h00);

    // 6: deselected read, then reset mid-stream
    for (int i = 0; i < 7; i++) push_byte(8'h70 + 8'(i));
    cs = 1'b1; addr = 2'd0; rd_en = 1'b1; step(); bus_idle();
    rd_reg("t6_count_cs", 2'd2, 8'h07);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    rd_reg("t6_count_rst", 2'd2, 8'h00);

    // Random traffic, including resets and CTRL writes
    for (int c = 0; c < 4000; c++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_byte  = 8'($urandom);
      cs       = ($urandom_range(0, 4) == 0);
      addr     = 2'($urandom);
      rd_en    = ($urandom_range(0, 2) == 0);
      wr_en    = ($urandom_range(0, 19) == 0);
      wdata    = 8'($urandom);
      step();
    end
    rst_n = 1'b1; rx_valid = 1'b0; bus_idle(); step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
